release_channel_arbiter: RTL

- Shares the single outbound release channel (TileLink C) between N requesters, e.g. the writeback unit (multi-beat Release/ProbeAckData) and the prober (single-beat ProbeAck).
- Arbitrates round-robin at message granularity and locks onto the winner until the last beat of a data-carrying message.
- Sits between the DCache release sources and the C-channel output queue.

---
 rtl/release_channel_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/release_channel_arbiter.sv
// rtl/release_channel_arbiter.sv - round-robin, message-locking arbiter for the shared release channel
module release_channel_arbiter #(
    parameter int N_REQ = 2,
    parameter int W     = 128,
    parameter int BEATS = 4,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W = (BEATS > 0) ? $clog2(BEATS + 1) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_bits,
    input  logic [N_REQ-1:0]     req_has_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_bits,
    output logic [SRC_W-1:0]     out_src,
    output logic                 busy,
    output logic [CNT_W-1:0]     beat_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam bit               MULTI     = (BEATS > 1);

    state_t           state;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] owner;
    logic [SRC_W-1:0] sel;
    logic [SRC_W-1:0] cur;
    logic             any_valid;
    logic             cur_valid;
    logic             fire;

    // (a + b) mod N_REQ, used for both the scan order and pointer advance
    function automatic logic [SRC_W-1:0] wrap_add(input int a, input int b);
        int s;
        s = (a + b) % N_REQ;
        return s[SRC_W-1:0];
    endfunction

    // Round-robin scan: walk backwards so the candidate closest to rr_ptr wins
    always_comb begin
        sel       = '0;
        any_valid = |req_valid;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(int'(rr_ptr), k)]) begin
                sel = wrap_add(int'(rr_ptr), k);
            end
        end
    end

    // Output mux: the locked owner overrides arbitration; reset blanks everything
    always_comb begin
        cur       = (state == LOCKED) ? owner : sel;
        cur_valid = (state == LOCKED) ? req_valid[owner] : any_valid;
        out_valid = !reset && cur_valid;
        out_src   = reset ? '0 : cur;
        out_bits  = '0;
        if (!reset && (state == LOCKED || any_valid)) begin
            out_bits = req_bits[int'(cur)*W +: W];
        end
        req_ready = '0;
        if (!reset && cur_valid && out_ready) begin
            req_ready[cur] = 1'b1;
        end
        fire = out_valid && out_ready;
        busy = (state == LOCKED);
    end

    // Arbitration state: lock on a data message, release after its last beat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else if (fire) begin
            case (state)
                IDLE: begin
                    if (MULTI && req_has_data[sel]) begin
                        state    <= LOCKED;
                        owner    <= sel;
                        beat_cnt <= CNT_W'(1);
                    end else begin
                        rr_ptr <= wrap_add(int'(sel), 1);
                    end
                end
                LOCKED: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        rr_ptr   <= wrap_add(int'(owner), 1);
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
